// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I control path: FSM states, opcodes,
// datapath select encodings and the per-state control word.
package riscv_ctrl_pkg;

    localparam int OP_W = 7;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR1    = 4'd11,
        JALR2    = 4'd12,
        LUI      = 4'd13,
        ILLEGAL  = 4'd14
    } state_e;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_READDATA  = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_IMMEXT    = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // fetch and memWrRetire mark the outputs that still depend on MemReady.
    typedef struct packed {
        logic        pcUpdate;
        logic        branch;
        logic        regWrite;
        logic        memWrite;
        logic        adrSrc;
        result_src_e resultSrc;
        alu_src_a_e  aluSrcA;
        alu_src_b_e  aluSrcB;
        alu_op_e     aluOp;
        logic        retire;
        logic        illegal;
        logic        fetch;
        logic        memWrRetire;
    } ctrl_t;

    function automatic ctrl_t ctrlFor(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            DECODE: begin
                c.aluSrcA = SRCA_OLDPC;
                c.aluSrcB = SRCB_IMM;
            end
            MEMADR, JALR1: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
            end
            MEMREAD: c.adrSrc = 1'b1;
            MEMWRITE: begin
                c.adrSrc      = 1'b1;
                c.memWrite    = 1'b1;
                c.memWrRetire = 1'b1;
            end
            MEMWB: begin
                c.resultSrc = RES_READDATA;
                c.regWrite  = 1'b1;
                c.retire    = 1'b1;
            end
            EXECR: begin
                c.aluSrcA = SRCA_RS1;
                c.aluOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.regWrite = 1'b1;
                c.retire   = 1'b1;
            end
            BRANCH: begin
                c.aluSrcA = SRCA_RS1;
                c.aluOp   = ALUOP_BRANCH;
                c.branch  = 1'b1;
                c.retire  = 1'b1;
            end
            JAL, JALR2: begin
                c.aluSrcA  = SRCA_OLDPC;
                c.aluSrcB  = SRCB_FOUR;
                c.pcUpdate = 1'b1;
            end
            LUI: begin
                c.resultSrc = RES_IMMEXT;
                c.regWrite  = 1'b1;
                c.retire    = 1'b1;
            end
            ILLEGAL: c.illegal = 1'b1;
            // FETCH and any unused encoding share the fetch control word.
            default: begin
                c.fetch     = 1'b1;
                c.resultSrc = RES_ALURESULT;
                c.aluSrcB   = SRCB_FOUR;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the main FSM (master) and the datapath (slave).
interface multicycle_ctrl_if #(
    parameter int OP_W = 7
);
    logic [OP_W-1:0] op;
    logic            Zero;
    logic            MemReady;
    logic            PCUpdate;
    logic            Branch;
    logic            RegWrite;
    logic            MemWrite;
    logic            IRWrite;
    logic            AdrSrc;
    logic [1:0]      ResultSrc;
    logic [1:0]      ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ALUOp;
    logic [2:0]      ImmSrc;
    logic            Retire;
    logic            Illegal;

    modport master (
        input  op, Zero, MemReady,
        output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Retire, Illegal
    );

    modport slave (
        output op, Zero, MemReady,
        input  PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Retire, Illegal
    );
endinterface

// File: rtl/multicycle_ctrl_immdec.sv
// Immediate-format decoder: purely combinational opcode to ImmSrc.
module instr_immdec
    import riscv_ctrl_pkg::*;
#(
    parameter int OP_W = 7
) (
    input  logic [OP_W-1:0] op_i,
    output logic [2:0]      immSrc_o
);

    // Opcodes without an immediate fall back to the I format.
    always_comb begin
        immSrc_o = IMM_I;
        case (op_i)
            OP_LW, OP_ITYPE, OP_JALR: immSrc_o = IMM_I;
            OP_SW:                    immSrc_o = IMM_S;
            OP_BRANCH:                immSrc_o = IMM_B;
            OP_JAL:                   immSrc_o = IMM_J;
            OP_LUI:                   immSrc_o = IMM_U;
            default:                  immSrc_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction
// and drives registered datapath selects and write enables.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int OP_W      = 7,
    parameter bit MEM_WAIT  = 1'b1,
    parameter bit TRAP_HALT = 1'b1
) (
    input logic             clk,
    input logic             reset,
    multicycle_ctrl_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctl_q;
    logic   rdy;
    logic   unusedZero;

    assign rdy        = MEM_WAIT ? bus.MemReady : 1'b1;
    assign unusedZero = bus.Zero;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = rdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECR;
                    OP_ITYPE:     state_d = EXECI;
                    OP_BRANCH:    state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALR1;
                    OP_LUI:       state_d = LUI;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = rdy ? MEMWB : MEMREAD;
            MEMWRITE: state_d = rdy ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, JALR2: state_d = ALUWB;
            JALR1:    state_d = JALR2;
            ILLEGAL:  state_d = TRAP_HALT ? ILLEGAL : FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // The control word is registered alongside the state so outputs come
    // straight from flops; reset lands on the fetch word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctl_q   <= ctrlFor(FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctrlFor(state_d);
        end
    end

    instr_immdec #(.OP_W(OP_W)) uImmDec (
        .op_i     (bus.op),
        .immSrc_o (bus.ImmSrc)
    );

    // Enables are masked by reset so an asynchronous reset silences them at once.
    assign bus.PCUpdate  = ~reset & (ctl_q.pcUpdate | (ctl_q.fetch & rdy));
    assign bus.IRWrite   = ~reset & ctl_q.fetch & rdy;
    assign bus.Branch    = ~reset & ctl_q.branch;
    assign bus.RegWrite  = ~reset & ctl_q.regWrite;
    assign bus.MemWrite  = ~reset & ctl_q.memWrite;
    assign bus.Retire    = ~reset & (ctl_q.retire | (ctl_q.memWrRetire & rdy));
    assign bus.Illegal   = ~reset & ctl_q.illegal;
    assign bus.AdrSrc    = ctl_q.adrSrc;
    assign bus.ResultSrc = ctl_q.resultSrc;
    assign bus.ALUSrcA   = ctl_q.aluSrcA;
    assign bus.ALUSrcB   = ctl_q.aluSrcB;
    assign bus.ALUOp     = ctl_q.aluOp;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its list of
// phases and every cycle's outputs are compared against the phase's expected word.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_JALR1, P_JALR2,
        P_LUI, P_ILLEGAL, P_RESET
    } phase_e;

    logic clk;
    logic reset;
    int   nVec;
    int   nErr;
    int   retireSeen;
    phase_e plan[$];
    logic [6:0] legalOps [8];

    multicycle_ctrl_if #(.OP_W(7)) bus ();

    multicycle_ctrl #(
        .OP_W      (7),
        .MEM_WAIT  (1'b1),
        .TRAP_HALT (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit immDefined(logic [6:0] o);
        return (o == OP_LW || o == OP_ITYPE || o == OP_JALR || o == OP_SW ||
                o == OP_BRANCH || o == OP_JAL || o == OP_LUI);
    endfunction

    function automatic logic [2:0] immFor(logic [6:0] o);
        if (o == OP_SW)     return 3'b001;
        if (o == OP_BRANCH) return 3'b010;
        if (o == OP_JAL)    return 3'b011;
        if (o == OP_LUI)    return 3'b100;
        return 3'b000;
    endfunction

    // Expected output word {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,
    // ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,Retire,Illegal} for one phase.
    function automatic logic [18:0] expectVec(phase_e p, bit rdy, logic [6:0] o);
        logic pc, br, rw, mw, ir, adr, ret, ill;
        logic [1:0] rs, a, b, aop;
        {pc, br, rw, mw, ir, adr, ret, ill} = '0;
        {rs, a, b, aop} = '0;
        case (p)
            P_FETCH:    begin pc = rdy; ir = rdy; rs = 2'b10; b = 2'b10; end
            P_RESET:    begin rs = 2'b10; b = 2'b10; end
            P_DECODE:   begin a = 2'b01; b = 2'b01; end
            P_MEMADR:   begin a = 2'b10; b = 2'b01; end
            P_MEMREAD:  adr = 1'b1;
            P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; ret = rdy; end
            P_MEMWB:    begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
            P_EXECR:    begin a = 2'b10; aop = 2'b10; end
            P_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            P_ALUWB:    begin rw = 1'b1; ret = 1'b1; end
            P_BRANCH:   begin a = 2'b10; aop = 2'b01; br = 1'b1; ret = 1'b1; end
            P_JAL:      begin a = 2'b01; b = 2'b10; pc = 1'b1; end
            P_JALR1:    begin a = 2'b10; b = 2'b01; end
            P_JALR2:    begin a = 2'b01; b = 2'b10; pc = 1'b1; end
            P_LUI:      begin rs = 2'b11; rw = 1'b1; ret = 1'b1; end
            P_ILLEGAL:  ill = 1'b1;
            default:    ill = 1'b0;
        endcase
        return {pc, br, rw, mw, ir, adr, rs, a, b, aop, immFor(o), ret, ill};
    endfunction

    task automatic checkOutput(phase_e p, bit rdy);
        logic [18:0] obs;
        logic [18:0] exp;
        obs = {bus.PCUpdate, bus.Branch, bus.RegWrite, bus.MemWrite, bus.IRWrite,
               bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
               bus.ImmSrc, bus.Retire, bus.Illegal};
        exp = expectVec(p, rdy, bus.op);
        if (!immDefined(bus.op)) begin
            obs[4:2] = 3'b000;
            exp[4:2] = 3'b000;
        end
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s op=%b rdy=%0d: observed %b expected %b",
                   p.name(), bus.op, rdy, obs, exp);
        end
    endtask

    task automatic stepCycle(phase_e p, bit rdy);
        bus.MemReady = rdy;
        bus.Zero     = 1'($urandom);
        @(negedge clk);
        checkOutput(p, rdy);
        retireSeen += int'(bus.Retire);
        @(posedge clk);
        #1;
    endtask

    task automatic buildPlan(logic [6:0] o);
        plan.delete();
        plan.push_back(P_FETCH);
        plan.push_back(P_DECODE);
        case (o)
            OP_LW:     begin plan.push_back(P_MEMADR); plan.push_back(P_MEMREAD); plan.push_back(P_MEMWB); end
            OP_SW:     begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWRITE); end
            OP_RTYPE:  begin plan.push_back(P_EXECR); plan.push_back(P_ALUWB); end
            OP_ITYPE:  begin plan.push_back(P_EXECI); plan.push_back(P_ALUWB); end
            OP_BRANCH: plan.push_back(P_BRANCH);
            OP_JAL:    begin plan.push_back(P_JAL); plan.push_back(P_ALUWB); end
            OP_JALR:   begin plan.push_back(P_JALR1); plan.push_back(P_JALR2); plan.push_back(P_ALUWB); end
            OP_LUI:    plan.push_back(P_LUI);
            default:   plan.push_back(P_ILLEGAL);
        endcase
    endtask

    // Runs one instruction from FETCH; memory phases see 'lows' not-ready cycles first.
    task automatic applyStimulus(logic [6:0] o, int fetchLows, int memLows, bit randomLows);
        int n;
        bit legal;
        bus.op = o;
        buildPlan(o);
        retireSeen = 0;
        legal = 1'b1;
        foreach (plan[k]) begin
            if (plan[k] == P_ILLEGAL) begin
                legal = 1'b0;
                for (int i = 0; i < 20; i++) stepCycle(P_ILLEGAL, 1'($urandom));
            end else if (plan[k] == P_FETCH || plan[k] == P_MEMREAD || plan[k] == P_MEMWRITE) begin
                if (randomLows)
                    n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
                else
                    n = (plan[k] == P_FETCH) ? fetchLows : memLows;
                for (int i = 0; i < n; i++) stepCycle(plan[k], 1'b0);
                stepCycle(plan[k], 1'b1);
            end else begin
                stepCycle(plan[k], 1'($urandom));
            end
        end
        nVec++;
        assert (retireSeen === (legal ? 1 : 0)) else begin
            nErr++;
            $error("[TB] FAIL retireCount op=%b: observed %0d expected %0d",
                   o, retireSeen, legal ? 1 : 0);
        end
    endtask

    initial begin
        legalOps = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
        nVec = 0;
        nErr = 0;
        reset = 1'b1;
        bus.op = OP_LW;
        bus.MemReady = 1'b1;
        bus.Zero = 1'b0;

        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput(P_RESET, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(OP_LW, 0, 0, 1'b0);
        applyStimulus(OP_SW, 0, 3, 1'b0);
        applyStimulus(OP_JALR, 0, 0, 1'b0);
        applyStimulus(OP_ITYPE, 2, 0, 1'b0);
        applyStimulus(OP_LUI, 0, 0, 1'b0);
        applyStimulus(OP_BRANCH, 0, 0, 1'b0);

        // Asynchronous reset while an R-type sits in EXECR.
        bus.op = OP_RTYPE;
        stepCycle(P_FETCH, 1'b1);
        stepCycle(P_DECODE, 1'b1);
        @(negedge clk);
        checkOutput(P_EXECR, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput(P_RESET, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput(P_RESET, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(OP_RTYPE, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++)
            applyStimulus(legalOps[$urandom_range(0, 7)], 0, 0, 1'b1);

        // Illegal opcode traps until reset, then execution resumes.
        applyStimulus(OP_FENCE, 0, 0, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput(P_RESET, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(OP_JAL, 0, 0, 1'b0);
        applyStimulus(OP_LW, 1, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
